// File: rtl/mem_arbiter.sv
// Two-port (instruction fetch / data) arbiter in front of a single-port synchronous RAM.
// Define ARB_ROUND_ROBIN_EN for alternating tie-break; default build gives data fixed priority.
module mem_arbiter #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,

    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,

    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_data,
    output logic          mem_wren,
    input  logic [DW-1:0] mem_q,

    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t        state_q, state_d;

    logic [AW-1:0] addr_q,     addr_d;
    logic [DW-1:0] wdata_q,    wdata_d;
    logic          we_q,       we_d;
    logic          win_d_q,    win_d_d;
    logic [DW-1:0] if_rdata_q, if_rdata_d;
    logic [DW-1:0] d_rdata_q,  d_rdata_d;

    logic          any_req;
    logic          pick_d;

    assign any_req = if_req | d_req;

`ifdef ARB_ROUND_ROBIN_EN
    // last_d_q remembers who won the previous grant; it starts at "data" so the first tie goes to fetch.
    logic last_d_q;

    always_comb begin
        if (if_req && d_req) begin
            pick_d = ~last_d_q;
        end else begin
            pick_d = d_req;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_d_q <= 1'b1;
        end else if (state_q == IDLE && any_req) begin
            last_d_q <= pick_d;
        end
    end
`else
    assign pick_d = d_req;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (any_req) state_d = ACCESS;
            ACCESS:  state_d = we_q ? IDLE : WAIT;
            WAIT:    state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        if_gnt    = 1'b0;
        d_gnt     = 1'b0;
        if_rvalid = 1'b0;
        d_rvalid  = 1'b0;
        mem_wren  = 1'b0;
        busy      = (state_q != IDLE);
        unique case (state_q)
            ACCESS: begin
                if_gnt   = ~win_d_q;
                d_gnt    = win_d_q;
                mem_wren = we_q;
            end
            RESP: begin
                if_rvalid = ~win_d_q;
                d_rvalid  = win_d_q;
            end
            default: ;
        endcase
    end

    // Request capture happens only in IDLE; fetch is always a read and never updates the write data.
    always_comb begin
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_d       = we_q;
        win_d_d    = win_d_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        if (state_q == IDLE && any_req) begin
            win_d_d = pick_d;
            if (pick_d) begin
                addr_d  = d_addr;
                wdata_d = d_wdata;
                we_d    = d_we;
            end else begin
                addr_d  = if_addr;
                we_d    = 1'b0;
            end
        end
        if (state_q == WAIT) begin
            if (win_d_q) begin
                d_rdata_d = mem_q;
            end else begin
                if_rdata_d = mem_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            win_d_q    <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            win_d_q    <= win_d_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    assign mem_addr = addr_q;
    assign mem_data = wdata_q;
    assign if_rdata = if_rdata_q;
    assign d_rdata  = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural synchronous RAM on the memory port.
// Contention expectations follow ARB_ROUND_ROBIN_EN when it is defined for the build.
module tb_mem_arbiter;

    localparam int AW = 8;
    localparam int DW = 8;

    logic          clk;
    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
    logic          mem_wren;
    logic [DW-1:0] mem_q;
    logic          busy;

    logic [DW-1:0] ram [0:(1<<AW)-1];

    int n_asserts;
    int n_fails;

    mem_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .mem_wren  (mem_wren),
        .mem_q     (mem_q),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port synchronous RAM: read data appears one clock after the address is sampled.
    always @(posedge clk) begin
        if (mem_wren) ram[mem_addr] <= mem_data;
        mem_q <= ram[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_asserts++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_gnt(output int who);
        who = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (if_gnt || d_gnt) begin
                check("gnt_onehot", {31'd0, if_gnt & d_gnt}, 32'd0);
                who = d_gnt ? 2 : 1;
                break;
            end
        end
    endtask

    int w0, w1, exp_w0, exp_w1;

    initial begin
        n_asserts = 0;
        n_fails   = 0;
        for (int i = 0; i < (1 << AW); i++) ram[i] = '0;
        ram[8'h05] = 8'hA7;
        mem_q   = '0;
        rst     = 1'b0;
        if_req  = 1'b0;
        if_addr = '0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_addr  = '0;
        d_wdata = '0;

        // Reset held for three clocks
        step(); step(); step();
        check("rst_busy",     {31'd0, busy},     32'd0);
        check("rst_outputs",  {28'd0, if_gnt, d_gnt, if_rvalid, d_rvalid}, 32'd0);
        check("rst_mem_addr", {24'd0, mem_addr}, 32'd0);
        check("rst_rdata",    {16'd0, if_rdata, d_rdata}, 32'd0);
        rst = 1'b1;
        step(); step();
        check("idle_busy",   {31'd0, busy}, 32'd0);
        check("idle_pulses", {27'd0, if_gnt, d_gnt, if_rvalid, d_rvalid, mem_wren}, 32'd0);

        // Fetch read of 0x05
        if_req  = 1'b1;
        if_addr = 8'h05;
        step();
        check("if_gnt_t1",    {31'd0, if_gnt},   32'd1);
        check("d_gnt_t1",     {31'd0, d_gnt},    32'd0);
        check("if_addr_t1",   {24'd0, mem_addr}, 32'h05);
        check("if_wren_t1",   {31'd0, mem_wren}, 32'd0);
        check("if_busy_t1",   {31'd0, busy},     32'd1);
        if_req = 1'b0;
        step();
        check("if_wait",      {30'd0, if_gnt, if_rvalid}, 32'd0);
        step();
        check("if_rvalid_t3", {31'd0, if_rvalid}, 32'd1);
        check("if_rdata_t3",  {24'd0, if_rdata},  32'hA7);
        check("d_rvalid_t3",  {31'd0, d_rvalid},  32'd0);
        step();
        check("if_rvalid_t4", {31'd0, if_rvalid}, 32'd0);
        check("if_idle_t4",   {31'd0, busy},      32'd0);
        check("if_rdata_hold",{24'd0, if_rdata},  32'hA7);

        // Data write 0x3C to 0x10
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 8'h10;
        d_wdata = 8'h3C;
        step();
        check("dw_gnt",   {30'd0, if_gnt, d_gnt}, 32'd1);
        check("dw_wren",  {31'd0, mem_wren},      32'd1);
        check("dw_addr",  {24'd0, mem_addr},      32'h10);
        check("dw_data",  {24'd0, mem_data},      32'h3C);
        d_req = 1'b0;
        d_we  = 1'b0;
        step();
        check("dw_busy_t2",  {31'd0, busy},       32'd0);
        check("dw_wren_t2",  {31'd0, mem_wren},   32'd0);
        check("dw_rvalid",   {30'd0, if_rvalid, d_rvalid}, 32'd0);
        check("dw_addr_hold",{24'd0, mem_addr},   32'h10);

        // Data read back of 0x10
        d_req  = 1'b1;
        d_addr = 8'h10;
        step();
        check("dr_gnt",  {30'd0, if_gnt, d_gnt}, 32'd1);
        check("dr_wren", {31'd0, mem_wren},      32'd0);
        d_req = 1'b0;
        step();
        step();
        check("dr_rvalid", {30'd0, if_rvalid, d_rvalid}, 32'd1);
        check("dr_rdata",  {24'd0, d_rdata},  32'h3C);
        check("dr_if_hold",{24'd0, if_rdata}, 32'hA7);
        step();

        // Contention: both requests held across two grants
`ifdef ARB_ROUND_ROBIN_EN
        exp_w0 = 1;
        exp_w1 = 2;
`else
        exp_w0 = 2;
        exp_w1 = 2;
`endif
        if_req  = 1'b1;
        if_addr = 8'h05;
        d_req   = 1'b1;
        d_we    = 1'b0;
        d_addr  = 8'h10;
        wait_gnt(w0);
        check("contend_first",  w0, exp_w0);
        wait_gnt(w1);
        check("contend_second", w1, exp_w1);
        if_req = 1'b0;
        d_req  = 1'b0;
        step();
        step();
        check("contend_rvalid", {30'd0, if_rvalid, d_rvalid}, 32'd1);
        check("contend_rdata",  {24'd0, d_rdata}, 32'h3C);
        step();
        check("contend_idle",   {31'd0, busy}, 32'd0);

        // Reset asserted during WAIT of a fetch read
        if_req  = 1'b1;
        if_addr = 8'h05;
        step();
        check("abort_gnt", {31'd0, if_gnt}, 32'd1);
        if_req = 1'b0;
        step();
        rst = 1'b0;
        #1;
        check("abort_busy",     {31'd0, busy}, 32'd0);
        check("abort_pulses",   {27'd0, if_gnt, d_gnt, if_rvalid, d_rvalid, mem_wren}, 32'd0);
        check("abort_mem_addr", {24'd0, mem_addr}, 32'd0);
        check("abort_rdata",    {16'd0, if_rdata, d_rdata}, 32'd0);
        #2;
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("abort_no_pulse", {28'd0, if_gnt, d_gnt, if_rvalid, d_rvalid}, 32'd0);
        end
        check("abort_idle", {31'd0, busy}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter AW, default 8, memory address width.
REQ-002 The block SHALL have parameter DW, default 8, memory data width.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 if_req  input  1  instruction-fetch request, held until if_gnt.
REQ-006 if_addr  input  AW  fetch address (PC value).
REQ-007 if_gnt  output  1  one-cycle fetch grant pulse.
REQ-008 if_rvalid  output  1  one-cycle fetch read-data-valid pulse.
REQ-009 if_rdata  output  DW  fetch read data.
REQ-010 d_req  input  1  data-access request, held until d_gnt.
REQ-011 d_we  input  1  data access type: 1 = write, 0 = read.
REQ-012 d_addr  input  AW  data address.
REQ-013 d_wdata  input  DW  data write value.
REQ-014 d_gnt  output  1  one-cycle data grant pulse.
REQ-015 d_rvalid  output  1  one-cycle data read-valid pulse.
REQ-016 d_rdata  output  DW  data read data.
REQ-017 mem_addr  output  AW  address to single-port synchronous RAM.
REQ-018 mem_data  output  DW  write data to RAM.
REQ-019 mem_wren  output  1  RAM write enable.
REQ-020 mem_q  input  DW  RAM read data, valid one clk after the address is sampled.
REQ-021 busy  output  1  high in every state except IDLE.

Function
REQ-022 The FSM SHALL have four states: IDLE, ACCESS, WAIT, RESP.
REQ-023 Requests SHALL be sampled only in IDLE. A request dropped before its grant SHALL cause no memory access.
REQ-024 In IDLE with any request at edge t, the winner's address, write data and type SHALL be latched, and the FSM SHALL enter ACCESS for cycle t+1.
REQ-025 In ACCESS the winner's gnt SHALL be high for exactly that cycle. mem_addr and mem_data SHALL drive the latched values, and mem_wren SHALL equal the latched type.
REQ-026 A write SHALL go ACCESS -> IDLE. There SHALL be no rvalid, and the next request is sampled at the end of t+2.
REQ-027 A read SHALL go ACCESS -> WAIT -> RESP -> IDLE. At the end of WAIT (t+2), mem_q SHALL be registered into the winner's rdata. The winner's rvalid SHALL be high for exactly cycle t+3.
REQ-028 if_rdata and d_rdata SHALL each hold their last value until their own next rvalid.
REQ-029 mem_wren SHALL be 0 in every state except a write ACCESS. In other states mem_addr and mem_data SHALL hold their last values.
REQ-030 Fetch requests SHALL always be reads (writes are never issued on the fetch side).
REQ-031 With no requests the FSM SHALL remain in IDLE, with all pulses low.
REQ-032 At most one of if_gnt and d_gnt SHALL be high in any cycle; likewise at most one of if_rvalid and d_rvalid.

Reset
REQ-033 Asserting rst (low) SHALL immediately force IDLE and clear all outputs, the latched request and the arbitration history, including mid-access.
REQ-034 An access aborted by reset SHALL never produce gnt or rvalid afterward.

Configuration
REQ-035 The macro ARB_ROUND_ROBIN_EN SHALL select the arbitration policy.
REQ-036 With ARB_ROUND_ROBIN_EN defined, a simultaneous request SHALL go to the requester not served last. A single history bit SHALL record the last winner, reset to "data", so the first tie goes to fetch.
REQ-037 With ARB_ROUND_ROBIN_EN undefined, data SHALL always win a simultaneous request (fixed priority). There SHALL be no history register.

Verification
REQ-038 Reset: rst low for 3 clks, then high -> all outputs 0, busy 0, and the FSM stays idle with no requests.
REQ-039 Fetch read: if_req=1, if_addr=0x05, mem_q returns 0xA7 -> if_gnt at t+1, mem_addr=0x05 at t+1, mem_wren=0, if_rvalid with if_rdata=0xA7 at t+3.
REQ-040 Data write: d_req=1, d_we=1, d_addr=0x10, d_wdata=0x3C -> d_gnt and mem_wren=1 with mem_addr=0x10 and mem_data=0x3C at t+1; no rvalid; busy low at t+2.
REQ-041 Contention: if_req and d_req held together for two grants -> fixed policy: data then data; round-robin: fetch then data.
REQ-042 Abort: rst low during WAIT of a read -> outputs cleared immediately; no rvalid ever appears for that read.
